neuron_mac: RTL

Per-neuron multiply-accumulate stage that sits directly downstream of a neuron's weight memory in the ELM hidden layer. For each input sample it issues the weight read (`ren`/`raddr`), multiplies the returned weight with the delayed input in signed fixed-point, and saturating-accumulates across one input vector of `numWeight` samples. It then adds the neuron bias and emits one saturated `dataWidth` result per vector to the activation stage.

---
 rtl/neuron_mac.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: one hidden-layer neuron. It reads a weight for every accepted
// input sample, multiplies the weight with the aligned sample in signed fixed
// point, and saturating-accumulates over one vector of numWeight samples. It
// then adds the bias and emits one saturated dataWidth result per vector.
module neuron_mac #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [dataWidth-1:0]        in_data,
    input  logic                        in_valid,
    input  logic [dataWidth-1:0]        bias,
    output logic                        ren,
    output logic [addressWidth:0]       raddr,
    input  logic [dataWidth-1:0]        wout,
    output logic [dataWidth-1:0]        out_data,
    output logic                        out_valid
);

    localparam int accWidth = 2 * dataWidth;

    localparam logic [addressWidth:0]        lastAddr = (addressWidth + 1)'(numWeight - 1);
    localparam logic signed [accWidth-1:0]   accMax   = {1'b0, {(accWidth - 1){1'b1}}};
    localparam logic signed [accWidth-1:0]   accMin   = {1'b1, {(accWidth - 1){1'b0}}};
    localparam logic [dataWidth-1:0]         outMax   = {1'b0, {(dataWidth - 1){1'b1}}};
    localparam logic [dataWidth-1:0]         outMin   = {1'b1, {(dataWidth - 1){1'b0}}};

    // Two's-complement add that clamps to the accumulator range instead of wrapping.
    function automatic logic signed [accWidth-1:0] sat_add(
        input logic signed [accWidth-1:0] a,
        input logic signed [accWidth-1:0] b
    );
        logic signed [accWidth:0] s;
        s = {a[accWidth-1], a} + {b[accWidth-1], b};
        if (s[accWidth] != s[accWidth-1]) begin
            sat_add = s[accWidth] ? accMin : accMax;
        end else begin
            sat_add = s[accWidth-1:0];
        end
    endfunction

    // Address counter and read issue
    logic [addressWidth:0] cnt;
    logic                  is_last;

    // Stage 1 (align with the 1-cycle memory read)
    logic signed [dataWidth-1:0] in_d;
    logic                        in_valid_d;
    logic                        last_d;

    // Stage 2 (multiply)
    logic signed [accWidth-1:0]  in_ext;
    logic signed [accWidth-1:0]  w_ext;
    logic signed [accWidth-1:0]  mul;
    logic                        mul_valid;
    logic                        mul_last;

    // Stage 3/4 (accumulate, bias, output)
    logic signed [accWidth-1:0]  acc;
    logic                        bias_pending;
    logic signed [accWidth-1:0]  acc_sum;
    logic signed [accWidth-1:0]  bias_ext;
    logic signed [accWidth-1:0]  bias_sum;
    logic signed [accWidth-1:0]  bias_shift;
    logic [dataWidth-1:0]        out_next;

    assign ren     = in_valid;
    assign raddr   = cnt;
    assign is_last = (cnt == lastAddr);

    // Step the weight address once per accepted sample, wrapping after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= is_last ? '0 : cnt + (addressWidth + 1)'(1);
        end
    end

    // Delay the sample and its flags by one cycle so they meet the returned weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_d       <= '0;
            in_valid_d <= 1'b0;
            last_d     <= 1'b0;
        end else begin
            if (in_valid) begin
                in_d <= $signed(in_data);
            end
            in_valid_d <= in_valid;
            last_d     <= in_valid & is_last;
        end
    end

    assign in_ext = accWidth'(in_d);
    assign w_ext  = accWidth'($signed(wout));

    // Full-width signed product; two dataWidth operands always fit in accWidth bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul       <= '0;
            mul_valid <= 1'b0;
            mul_last  <= 1'b0;
        end else begin
            if (in_valid_d) begin
                mul <= in_ext * w_ext;
            end
            mul_valid <= in_valid_d;
            mul_last  <= in_valid_d & last_d;
        end
    end

    // Combinational saturating sums, bias alignment and output clamp.
    always_comb begin
        acc_sum    = sat_add(acc, mul);
        bias_ext   = {{(accWidth - dataWidth){bias[dataWidth-1]}}, bias} << fracBits;
        bias_sum   = sat_add(acc, bias_ext);
        bias_shift = bias_sum >>> fracBits;
        out_next   = bias_shift[dataWidth-1:0];
        if (!((&bias_shift[accWidth-1:dataWidth-1]) || !(|bias_shift[accWidth-1:dataWidth-1]))) begin
            out_next = bias_shift[accWidth-1] ? outMin : outMax;
        end
    end

    // Accumulate products; on the bias cycle restart from the product arriving that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            bias_pending <= 1'b0;
        end else begin
            if (bias_pending) begin
                acc <= mul_valid ? mul : '0;
            end else if (mul_valid) begin
                acc <= acc_sum;
            end
            bias_pending <= mul_last;
        end
    end

    // Register the biased, clamped result and pulse out_valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (bias_pending) begin
                out_data <= out_next;
            end
            out_valid <= bias_pending;
        end
    end

endmodule
